cmp_operand_gen: RTL and testbench
==================================

# cmp_operand_gen

Self-test operand source for the comparator family: a handshaked transmitter that produces pseudo-random operand pairs `a`/`b` for a comparator under test. Operand `b` is `a` with a sparse random bit mask applied, so pairs are near-equal and exercise the long carry/equality chains of the comparator. Sits in front of a `less` instance in on-chip BIST wrappers; a downstream checker consumes the pair and the comparator result.

## Interface
- `WIDTH`, 12: operand width, 1..64.
- `SEED`, 32'h0000_0001: LFSR reset value; 0 is replaced by 1.
- `COUNT`, 1000: pairs per run; 0 = free-run until reset.

- `clk`  in  1  clock, all state on rising edge.
- `arst_n`  in  1  reset, asynchronous assert, active-low; one clock, asynchronous active-low reset (fixed).
- `start`  in  1  sampled in IDLE only; begins a run.
- `ready`  in  1  downstream accepts pair when `valid & ready`.
- `valid`  out  1  pair on `a`/`b` is valid.
- `a`  out  WIDTH  operand A.
- `b`  out  WIDTH  operand B.
- `busy`  out  1  high in any state except IDLE.
- `done`  out  1  one-cycle pulse after the last pair of a run is accepted.
- `pair_cnt`  out  32  pairs accepted in the current or last run.

## Operation
- LFSR: 32-bit Galois, taps for x^32+x^22+x^2+x+1 (mask 32'h8020_0003), shift right, feedback from bit 0. Advances exactly once in each of LOAD_A, MASK1, MASK2, MASK3; holds otherwise. It is not reseeded on `start`, so successive runs differ.
- FSM states: IDLE, LOAD_A, MASK1, MASK2, MASK3, PRESENT, FINISH.
  - IDLE: `start`=1 -> LOAD_A; clear `pair_cnt`.
  - LOAD_A: `a <= ((a << 32) ^ lfsr)` truncated to WIDTH, so WIDTH>32 fills across pairs -> MASK1.
  - MASK1: `m <= lfsr[..]` (zero-extended/truncated to WIDTH) -> MASK2.
  - MASK2: `m <= m & lfsr` -> MASK3.
  - MASK3: `b <= a ^ (m & lfsr)`; `valid <= 1` -> PRESENT.
  - PRESENT: hold `a`, `b`, `valid`. On `valid & ready`: `pair_cnt++`, `valid <= 0`; if COUNT≠0 and new count == COUNT -> FINISH, else -> LOAD_A.
  - FINISH: `done`=1 for this cycle only -> IDLE.
- `start` outside IDLE is ignored. `a`/`b` keep the last values in IDLE.
- `pair_cnt` wraps at 2^32 in free-run.

## Timing
- Reset values: `valid`=0, `busy`=0, `done`=0, `a`=0, `b`=0, `pair_cnt`=0, state IDLE, LFSR=SEED (or 1). Outputs go to these values immediately on `arst_n` falling, regardless of state.
- Reset deasserted mid-run: FSM restarts in IDLE and waits for `start`; no partial pair is ever presented.
- Latency: `start` sampled at edge E0 -> `valid` high after E4 (4 cycles).
- Throughput: with `ready` held high, one pair per 5 cycles (PRESENT + 4 generation states).
- `a`/`b` change only on the edge leaving LOAD_A/MASK3; stable throughout `valid`.
- `done` rises on the edge after the final handshake; `busy` falls one cycle later.
- `ready` is ignored when `valid`=0.

## Configuration
- `CMP_OPGEN_GOLDEN_EN` defined: adds output `expect_lt` (1 bit), registered together with `b` in MASK3 as `a < (a ^ mask)` (unsigned), reset value 0, held with the pair. This lets the checker compare against the comparator result without its own model.
- Not defined: the port and its logic are absent; all other behaviour is identical.

## Test plan
- Reset idle: assert `arst_n`=0 mid-PRESENT -> `valid`, `busy`, `a`, `b`, `pair_cnt` = 0 in the same cycle; no `valid` after release until `start`.
- COUNT=3, `ready`=1, one `start` pulse -> exactly 3 handshakes spaced 5 cycles apart, first `valid` 4 cycles after `start`; `done` pulse once; `pair_cnt`=3; `busy` low 1 cycle after `done`.
- Backpressure: `ready`=0 for 10 cycles in PRESENT -> `a`/`b`/`valid` bit-stable; release -> 1 handshake, `pair_cnt` +1.
- Model match, SEED=1, WIDTH=12 and WIDTH=40: bench LFSR model -> every `a`, and `b ^ a` == AND of the 3 masks, bit-exact for 1000 pairs.
- `start` pulses while busy and a second `start` after `done` -> first ignored; second run's first pair ≠ first run's first pair; `pair_cnt` restarts at 0.
- With `CMP_OPGEN_GOLDEN_EN`, a `less` instance fed by the block -> `out` == `expect_lt` on every handshake for 10000 pairs.

Source files
------------

// File: rtl/cmp_operand_gen_if.sv
`default_nettype none
// ============================================================================
//  Module      : cmp_operand_gen_if
//  Description : Pair bus between the comparator operand generator and its
//                consumer. Carries valid/ready handshake plus operands a, b.
//                Optional macro CMP_OPGEN_GOLDEN_EN adds the expect_lt
//                reference bit that travels with each pair.
//  Signals     : valid     generator -> consumer, pair on a/b is valid
//                ready     consumer  -> generator, pair accepted on valid&ready
//                a, b      generator -> consumer, WIDTH-bit operands
//                expect_lt generator -> consumer, a < b (only with the macro)
//  Revision    : 1.0  initial release
// ============================================================================
interface cmp_operand_gen_if #(
  parameter int WIDTH = 12
);
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
`ifdef CMP_OPGEN_GOLDEN_EN
  logic             expect_lt;

  modport master (input ready, output valid, a, b, expect_lt);
  modport slave  (output ready, input valid, a, b, expect_lt);
`else
  modport master (input ready, output valid, a, b);
  modport slave  (output ready, input valid, a, b);
`endif
endinterface
`default_nettype wire

// File: rtl/cmp_operand_gen.sv
`default_nettype none
// ============================================================================
//  Module      : cmp_operand_gen
//  Description : Self-test operand source for comparator BIST. Produces
//                pseudo-random near-equal operand pairs: a comes from a 32-bit
//                Galois LFSR, b is a with a sparse mask (AND of three LFSR
//                words) flipped. Pairs leave over a valid/ready handshake.
//                Optional macro CMP_OPGEN_GOLDEN_EN adds the expect_lt output
//                (unsigned a < b) registered together with b.
//  Ports       : clk       clock, rising edge
//                arst_n    asynchronous active-low reset
//                start     begins a run (sampled in IDLE only)
//                busy      high in every state except IDLE
//                done      one-cycle pulse after the last pair of a run
//                pair_cnt  pairs accepted in the current or last run
//                bus       master side of cmp_operand_gen_if (valid/ready/a/b)
//  Parameters  : WIDTH operand width 1..64, SEED LFSR reset value (0 -> 1),
//                COUNT pairs per run (0 = free-run)
//  Revision    : 1.0  initial release
// ============================================================================
module cmp_operand_gen #(
  parameter int          WIDTH = 12,
  parameter logic [31:0] SEED  = 32'h0000_0001,
  parameter int          COUNT = 1000
) (
  input  wire logic        clk,
  input  wire logic        arst_n,
  input  wire logic        start,
  output logic             busy,
  output logic             done,
  output logic [31:0]      pair_cnt,
  cmp_operand_gen_if.master bus
);

  // An all-zero Galois LFSR would lock up, so a zero seed becomes 1.
  localparam logic [31:0] SEED_NZ  = (SEED == 32'h0) ? 32'h1 : SEED;
  localparam logic [31:0] TAPS     = 32'h8020_0003;
  localparam logic [31:0] COUNT_W  = 32'(COUNT);
  localparam bit          FREE_RUN = (COUNT == 0);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD_A  = 3'd1,
    S_MASK1   = 3'd2,
    S_MASK2   = 3'd3,
    S_MASK3   = 3'd4,
    S_PRESENT = 3'd5,
    S_FINISH  = 3'd6
  } state_t;

  state_t             state_q, state_d;
  logic [31:0]        lfsr_q, lfsr_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic               valid_q, valid_d;
  logic [31:0]        cnt_q, cnt_d;

  logic [31:0]        lfsr_step;
  logic [WIDTH-1:0]   lfsr_trunc;   // LFSR word zero-extended/truncated to WIDTH
  logic [WIDTH-1:0]   a_load;       // ((a << 32) ^ lfsr) truncated to WIDTH
  logic [WIDTH-1:0]   mask_fin;     // final sparse mask used for b
  logic [31:0]        cnt_inc;

  // Shift right, feedback from bit 0 folded into the tap positions.
  assign lfsr_step = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? TAPS : 32'h0);

  // For narrow operands the shifted-out a contributes nothing; wide operands
  // keep their low bits and accumulate a fresh LFSR word per pair.
  generate
    if (WIDTH <= 32) begin : g_narrow
      assign lfsr_trunc = lfsr_q[WIDTH-1:0];
      assign a_load     = lfsr_trunc;
    end else begin : g_wide
      assign lfsr_trunc = {{(WIDTH-32){1'b0}}, lfsr_q};
      assign a_load     = {a_q[WIDTH-33:0], 32'h0} ^ lfsr_trunc;
    end
  endgenerate

  assign mask_fin = m_q & lfsr_trunc;
  assign cnt_inc  = cnt_q + 32'd1;

`ifdef CMP_OPGEN_GOLDEN_EN
  logic lt_q, lt_d;
`else
  // Golden reference bit not built.
`endif

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    a_d     = a_q;
    b_d     = b_q;
    m_d     = m_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
`ifdef CMP_OPGEN_GOLDEN_EN
    lt_d    = lt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD_A;
          cnt_d   = 32'h0;
        end
      end
      S_LOAD_A: begin
        a_d     = a_load;
        lfsr_d  = lfsr_step;
        state_d = S_MASK1;
      end
      S_MASK1: begin
        m_d     = lfsr_trunc;
        lfsr_d  = lfsr_step;
        state_d = S_MASK2;
      end
      S_MASK2: begin
        m_d     = m_q & lfsr_trunc;
        lfsr_d  = lfsr_step;
        state_d = S_MASK3;
      end
      S_MASK3: begin
        b_d     = a_q ^ mask_fin;
        valid_d = 1'b1;
`ifdef CMP_OPGEN_GOLDEN_EN
        lt_d    = (a_q < (a_q ^ mask_fin));
`endif
        lfsr_d  = lfsr_step;
        state_d = S_PRESENT;
      end
      S_PRESENT: begin
        if (valid_q && bus.ready) begin
          cnt_d   = cnt_inc;
          valid_d = 1'b0;
          if (!FREE_RUN && (cnt_inc == COUNT_W)) begin
            state_d = S_FINISH;
          end else begin
            state_d = S_LOAD_A;
          end
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= S_IDLE;
      lfsr_q  <= SEED_NZ;
      a_q     <= '0;
      b_q     <= '0;
      m_q     <= '0;
      valid_q <= 1'b0;
      cnt_q   <= 32'h0;
`ifdef CMP_OPGEN_GOLDEN_EN
      lt_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      a_q     <= a_d;
      b_q     <= b_d;
      m_q     <= m_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
`ifdef CMP_OPGEN_GOLDEN_EN
      lt_q    <= lt_d;
`endif
    end
  end

  // done/busy decode from state so they clear the instant reset asserts.
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_FINISH);
  assign pair_cnt  = cnt_q;
  assign bus.valid = valid_q;
  assign bus.a     = a_q;
  assign bus.b     = b_q;
`ifdef CMP_OPGEN_GOLDEN_EN
  assign bus.expect_lt = lt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cmp_operand_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cmp_operand_gen
//  Description : Bench for cmp_operand_gen. Two instances (WIDTH 12 and 40,
//                COUNT 3) share start/ready; a reference LFSR model pushes the
//                expected pairs of each run into a queue that a handshake
//                monitor pops and compares.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cmp_operand_gen;

  localparam int COUNT = 3;
  localparam int W1    = 12;
  localparam int W2    = 40;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        start;
  logic        ready;
  logic        busy12, done12, busy40, done40;
  logic [31:0] cnt12, cnt40;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  cmp_operand_gen_if #(.WIDTH(W1)) if12 ();
  cmp_operand_gen_if #(.WIDTH(W2)) if40 ();
  assign if12.ready = ready;
  assign if40.ready = ready;

  cmp_operand_gen #(.WIDTH(W1), .SEED(32'h1), .COUNT(COUNT)) u12 (
    .clk(clk), .arst_n(arst_n), .start(start), .busy(busy12),
    .done(done12), .pair_cnt(cnt12), .bus(if12.master));

  cmp_operand_gen #(.WIDTH(W2), .SEED(32'h1), .COUNT(COUNT)) u40 (
    .clk(clk), .arst_n(arst_n), .start(start), .busy(busy40),
    .done(done40), .pair_cnt(cnt40), .bus(if40.master));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  typedef struct {
    logic [63:0] a12, b12, a40, b40;
    logic        lt12, lt40;
  } exp_t;

  exp_t        sbq[$];
  int          hs_cyc[$];
  logic [11:0] hs_a[$];
  logic [31:0] m_lfsr;
  logic [39:0] m_a40;

  function automatic logic [31:0] lfsr_next(input logic [31:0] x);
    return {1'b0, x[31:1]} ^ (x[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  task automatic model_reset();
    m_lfsr = 32'h1;
    m_a40  = '0;
    sbq.delete();
  endtask

  task automatic push_expected(input int n);
    logic [31:0] l0, l1, l2, l3, msk;
    exp_t e;
    for (int i = 0; i < n; i++) begin
      l0 = m_lfsr;
      l1 = lfsr_next(l0);
      l2 = lfsr_next(l1);
      l3 = lfsr_next(l2);
      m_lfsr = lfsr_next(l3);
      msk = l1 & l2 & l3;
      e.a12 = {52'h0, l0[11:0]};
      e.b12 = e.a12 ^ {52'h0, msk[11:0]};
      m_a40 = {m_a40[7:0], l0};
      e.a40 = {24'h0, m_a40};
      e.b40 = e.a40 ^ {32'h0, msk};
      e.lt12 = (e.a12 < e.b12);
      e.lt40 = (e.a40 < e.b40);
      sbq.push_back(e);
    end
  endtask

  // Handshake monitor: a pair is taken at the next rising edge.
  always @(negedge clk) begin : mon
    exp_t e;
    if (arst_n === 1'b1 && if12.valid === 1'b1 && ready === 1'b1) begin
      hs_cyc.push_back(cyc);
      hs_a.push_back(if12.a);
      if (sbq.size() == 0) begin
        check("sb_underflow", 64'(sbq.size()), 64'd1);
      end else begin
        e = sbq.pop_front();
        check("a12", {52'h0, if12.a}, e.a12);
        check("b12", {52'h0, if12.b}, e.b12);
        check("a40", {24'h0, if40.a}, e.a40);
        check("b40", {24'h0, if40.b}, e.b40);
        check("valid40", 64'(if40.valid), 64'd1);
`ifdef CMP_OPGEN_GOLDEN_EN
        check("lt12", 64'(if12.expect_lt), 64'(e.lt12));
        check("lt40", 64'(if40.expect_lt), 64'(e.lt40));
`endif
      end
    end
  end

  // rmode 0: ready held high; 1: random ready; 2: backpressure on first pair
  // plus a stray start pulse mid-run.
  task automatic run_pairs(input int rmode, output logic [11:0] first_a);
    int          e0, first_v, dcyc;
    bit          got_done, bp_done;
    logic [11:0] ha, hb;
    logic [39:0] ha40, hb40;
    logic [31:0] c0;
    first_v = -1; dcyc = 0; got_done = 0; bp_done = 0;
    push_expected(COUNT);
    hs_cyc.delete();
    hs_a.delete();
    ready = (rmode == 2) ? 1'b0 : 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    e0 = cyc;
    start = 1'b0;
    check("cnt_restart", 64'(cnt12), 64'd0);
    check("busy_start", 64'(busy12), 64'd1);
    for (int it = 0; it < 400; it++) begin
      if (if12.valid && first_v < 0) first_v = cyc - e0;
      if (done12) begin
        got_done = 1;
        dcyc = cyc;
        break;
      end
      start = (rmode == 2 && it == 2) ? 1'b1 : 1'b0;
      if (rmode == 2 && if12.valid && !bp_done) begin
        ha = if12.a; hb = if12.b; ha40 = if40.a; hb40 = if40.b;
        repeat (10) begin
          @(posedge clk); #1;
          check("bp_a", 64'(if12.a), 64'(ha));
          check("bp_b", 64'(if12.b), 64'(hb));
          check("bp_a40", 64'(if40.a), 64'(ha40));
          check("bp_b40", 64'(if40.b), 64'(hb40));
          check("bp_valid", 64'(if12.valid), 64'd1);
        end
        c0 = cnt12;
        ready = 1'b1;
        bp_done = 1;
        @(posedge clk); #1;
        check("bp_cnt", 64'(cnt12), 64'(c0 + 32'd1));
        check("bp_valid_drop", 64'(if12.valid), 64'd0);
        continue;
      end
      if (rmode == 1) ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    start = 1'b0;
    check("done_seen", 64'(got_done), 64'd1);
    if (got_done) begin
      check("latency", 64'(first_v), 64'd4);
      check("hs_count", 64'(hs_cyc.size()), 64'(COUNT));
      check("cnt_final", 64'(cnt12), 64'(COUNT));
      check("cnt40_final", 64'(cnt40), 64'(COUNT));
      check("busy_in_finish", 64'(busy12), 64'd1);
      check("done40", 64'(done40), 64'd1);
      if (hs_cyc.size() > 0) check("done_after_hs", 64'(dcyc - hs_cyc[$]), 64'd1);
      if (rmode == 0 && hs_cyc.size() == COUNT) begin
        check("first_hs", 64'(hs_cyc[0] - e0), 64'd4);
        for (int i = 1; i < COUNT; i++)
          check("spacing", 64'(hs_cyc[i] - hs_cyc[i-1]), 64'd5);
      end
      @(posedge clk); #1;
      check("done_pulse", 64'(done12), 64'd0);
      check("busy_fall", 64'(busy12), 64'd0);
      check("busy40_fall", 64'(busy40), 64'd0);
    end
    first_a = (hs_a.size() > 0) ? hs_a[0] : 12'h0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, 64'(if12.valid), 64'd0);
    check({tag, "_busy"},  64'(busy12), 64'd0);
    check({tag, "_done"},  64'(done12), 64'd0);
    check({tag, "_a"},     64'(if12.a), 64'd0);
    check({tag, "_b"},     64'(if12.b), 64'd0);
    check({tag, "_cnt"},   64'(cnt12), 64'd0);
    check({tag, "_a40"},   64'(if40.a), 64'd0);
    check({tag, "_b40"},   64'(if40.b), 64'd0);
  endtask

  initial begin : watchdog
    #900_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [11:0] fa1, fa2, fdummy;
    bit          saw;
    arst_n = 1'b0; start = 1'b0; ready = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_zero("rst");
    arst_n = 1'b1;
    @(posedge clk); #1;

    run_pairs(0, fa1);
    run_pairs(2, fa2);
    check("run2_differs", 64'(fa1 != fa2), 64'd1);

    // Reset while a pair is presented and held by backpressure.
    push_expected(COUNT);
    ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 50 && cnt12 != 32'd1; i++) begin
      @(posedge clk); #1;
    end
    ready = 1'b0;
    check("cnt_before_rst", 64'(cnt12), 64'd1);
    for (int i = 0; i < 20 && !if12.valid; i++) begin
      @(posedge clk); #1;
    end
    check("valid_before_rst", 64'(if12.valid), 64'd1);
    #2 arst_n = 1'b0;
    #1 check_zero("async_rst");
    model_reset();
    @(posedge clk); #1;
    @(posedge clk); #1;
    arst_n = 1'b1;
    ready = 1'b1;
    saw = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (if12.valid || busy12) saw = 1;
    end
    check("idle_after_rst", 64'(saw), 64'd0);

    // Bulk model match with random backpressure, >1000 pairs.
    for (int r = 0; r < 335; r++) run_pairs(1, fdummy);

    check("sb_empty", 64'(sbq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
